// File: rtl/systolic_array_ctrl.sv
// Sequencer for an NxN systolic array: accepts two operand matrices, clears the
// array, feeds A by columns and B by rows, then holds the product until taken.
module systolic_array_ctrl #(
  parameter int N       = 3,
  parameter int DW      = 8,
  parameter int CW      = 16,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [N*N*DW-1:0] a_mat,
  input  logic [N*N*DW-1:0] b_mat,
  output logic              sa_clear,
  output logic [N*DW-1:0]   sa_a,
  output logic [N*DW-1:0]   sa_b,
  input  logic              sa_valid,
  input  logic [N*N*CW-1:0] sa_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N*N*CW-1:0] res_c,
  output logic              res_err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, RESP} state_t;

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t              state, next_state;
  logic [KW-1:0]       k, next_k;
  logic [TW-1:0]       tmo_cnt;
  logic [N*N*DW-1:0]   a_reg, b_reg;
  logic [N*DW-1:0]     a_beat, b_beat;
  logic                tmo_last;

  assign tmo_last    = (tmo_cnt == T_LAST);
  assign start_ready = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; sa_valid is only looked at while flushing.
  always_comb begin
    // NOTE: assign a default before the case so every path drives the variable; otherwise a latch is inferred.
    next_state = state;
    case (state)
      IDLE:    if (start_valid)            next_state = CLEAR;
      CLEAR:                               next_state = FEED;
      FEED:    if (k == K_LAST)            next_state = FLUSH;
      FLUSH:   if (sa_valid || tmo_last)   next_state = RESP;
      RESP:    if (res_ready)              next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
  end

  // Output decode: the beat for the coming cycle, so the operand outputs can be registered.
  always_comb begin
    next_k = '0;
    if (state == FEED) next_k = k + 1'b1;
    a_beat = '0;
    b_beat = '0;
    for (int i = 0; i < N; i++) begin
      a_beat[i*DW +: DW] = a_reg[(i*N + int'(next_k))*DW +: DW];
      b_beat[i*DW +: DW] = b_reg[(int'(next_k)*N + i)*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      k         <= '0;
      tmo_cnt   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sa_clear  <= 1'b0;
      sa_a      <= '0;
      sa_b      <= '0;
      res_valid <= 1'b0;
      res_c     <= '0;
      res_err   <= 1'b0;
    end else begin
      if (state == IDLE && start_valid) begin
        a_reg <= a_mat;
        b_reg <= b_mat;
      end
      k         <= next_k;
      tmo_cnt   <= (state == FLUSH) ? tmo_cnt + 1'b1 : '0;
      sa_clear  <= (next_state == CLEAR);
      sa_a      <= (next_state == FEED) ? a_beat : '0;
      sa_b      <= (next_state == FEED) ? b_beat : '0;
      res_valid <= (next_state == RESP);
      if (state == FLUSH) begin
        if (sa_valid) begin
          res_c   <= sa_c;
          res_err <= 1'b0;
        end else if (tmo_last) begin
          res_c   <= '0;
          res_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl with a behavioural 3x3 array model
// and a result scoreboard filled when each job is issued.
module tb_systolic_array_ctrl;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int TO = 32;
  localparam int AW = N*N*DW;
  localparam int RW = N*N*CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [AW-1:0] a_mat = '0;
  logic [AW-1:0] b_mat = '0;
  logic          start_ready, sa_clear, res_valid, res_err, busy;
  logic          sa_valid;
  logic [N*DW-1:0] sa_a, sa_b;
  logic [RW-1:0] sa_c, res_c;

  int            tests = 0;
  int            fails = 0;
  int            clr_cnt = 0;
  logic [RW-1:0] exp_q[$];
  bit            err_q[$];
  bit            stale_hold = 1'b0;
  bit            never_valid = 1'b0;
  int            resp_delay = 0;

  always #5 clk = ~clk;

  systolic_array_ctrl #(.N(N), .DW(DW), .CW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a_mat(a_mat), .b_mat(b_mat), .sa_clear(sa_clear), .sa_a(sa_a), .sa_b(sa_b),
    .sa_valid(sa_valid), .sa_c(sa_c), .res_valid(res_valid), .res_ready(res_ready),
    .res_c(res_c), .res_err(res_err), .busy(busy)
  );

  // Array model: the N beats after a clear are accumulated; the result appears
  // resp_delay cycles after the last beat. stale_hold keeps the old valid through CLEAR/FEED.
  int            acc[N][N];
  int            m_cnt, m_dly;
  bit            m_feed = 1'b0;
  bit            m_pend = 1'b0;
  logic [RW-1:0] m_tmp;

  always @(posedge clk) begin
    if (sa_clear) clr_cnt++;
    if (rst) begin
      m_feed = 1'b0;
      m_pend = 1'b0;
      sa_valid <= 1'b0;
      sa_c     <= '0;
    end else begin
      if (sa_clear) begin
        foreach (acc[i, j]) acc[i][j] = 0;
        m_feed = 1'b1;
        m_cnt  = 0;
        m_pend = 1'b0;
        if (!stale_hold) sa_valid <= 1'b0;
      end else if (m_feed) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] += int'(sa_a[i*DW +: DW]) * int'(sa_b[j*DW +: DW]);
        m_cnt++;
        if (m_cnt == N) begin
          m_feed = 1'b0;
          sa_valid <= 1'b0;
          m_pend = !never_valid;
          m_dly  = resp_delay;
        end
      end
      if (m_pend) begin
        if (m_dly == 0) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              m_tmp[(i*N+j)*CW +: CW] = CW'(acc[i][j]);
          sa_c     <= m_tmp;
          sa_valid <= 1'b1;
          m_pend = 1'b0;
        end else begin
          m_dly--;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] pack_m(input int m[9]);
    pack_m = '0;
    for (int e = 0; e < N*N; e++) pack_m[e*DW +: DW] = DW'(m[e]);
  endfunction

  function automatic logic [RW-1:0] pack_c(input int m[9]);
    pack_c = '0;
    for (int e = 0; e < N*N; e++) pack_c[e*CW +: CW] = CW'(m[e]);
  endfunction

  function automatic logic [RW-1:0] matmul(input logic [AW-1:0] a, input logic [AW-1:0] b);
    int s;
    matmul = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'(a[(i*N+k)*DW +: DW]) * int'(b[(k*N+j)*DW +: DW]);
        matmul[(i*N+j)*CW +: CW] = CW'(s);
      end
  endfunction

  // Issues one job from an idle controller and follows it through to the handshake.
  task automatic run_job(input string name, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [RW-1:0] exp_c, input bit exp_err, input int exp_lat,
                         input int hold);
    int              c0, n;
    logic [N*DW-1:0] ea, eb;
    logic [RW-1:0]   held, e_c;
    bit              e_err;
    check({name, " start_ready idle"}, start_ready, 1);
    c0 = clr_cnt;
    a_mat = a;
    b_mat = b;
    start_valid = 1'b1;
    exp_q.push_back(exp_c);
    err_q.push_back(exp_err);
    @(negedge clk);
    start_valid = 1'b0;
    a_mat = '1;
    b_mat = '1;
    check({name, " sa_clear"}, sa_clear, 1);
    check({name, " busy"}, busy, 1);
    check({name, " start_ready busy"}, start_ready, 0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        ea[i*DW +: DW] = a[(i*N+k)*DW +: DW];
        eb[i*DW +: DW] = b[(k*N+i)*DW +: DW];
      end
      check($sformatf("%s beat%0d sa_a", name, k), sa_a, ea);
      check($sformatf("%s beat%0d sa_b", name, k), sa_b, eb);
      if (k == 0) check({name, " sa_clear low"}, sa_clear, 0);
    end
    @(negedge clk);
    n = 0;
    check({name, " flush sa_a"}, sa_a, 0);
    check({name, " flush sa_b"}, sa_b, 0);
    while (!res_valid && n < TO + 4) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, n, exp_lat);
    e_c   = exp_q.pop_front();
    e_err = err_q.pop_front();
    check({name, " res_c"}, res_c, e_c);
    check({name, " res_err"}, res_err, e_err);
    held = res_c;
    for (int h = 0; h < hold; h++) begin
      start_valid = 1'b1;
      a_mat = pack_m('{9{5}});
      @(negedge clk);
      check({name, " hold res_valid"}, res_valid, 1);
      check({name, " hold res_c"}, res_c, held);
      check({name, " hold start_ready"}, start_ready, 0);
      check({name, " hold sa_clear"}, sa_clear, 0);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({name, " res_valid drop"}, res_valid, 0);
    check({name, " start_ready back"}, start_ready, 1);
    check({name, " busy idle"}, busy, 0);
    check({name, " clear pulses"}, clr_cnt, c0 + 1);
  endtask

  int m1[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int m2[9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
  int m3[9] = '{2, 0, 1, 3, 7, 4, 1, 1, 6};
  int r1[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
  int r2[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  initial begin
    int seen;
    repeat (2) begin
      @(negedge clk);
      check("rst start_ready", start_ready, 0);
      check("rst busy", busy, 0);
      check("rst sa_clear", sa_clear, 0);
      check("rst sa_a", sa_a, 0);
      check("rst res_valid", res_valid, 0);
      check("rst res_c", res_c, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post-rst start_ready", start_ready, 1);

    stale_hold = 1'b1;
    resp_delay = 0;
    run_job("job1", pack_m(m1), pack_m(m1), pack_c(r1), 1'b0, 1, 0);
    resp_delay = 2;
    run_job("job2", pack_m(m1), pack_m(m2), pack_c(r2), 1'b0, 3, 5);
    stale_hold = 1'b0;

    a_mat = pack_m(m3);
    b_mat = pack_m(m2);
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst sa_clear", sa_clear, 0);
    check("midrst sa_a", sa_a, 0);
    check("midrst sa_b", sa_b, 0);
    check("midrst res_valid", res_valid, 0);
    check("midrst res_c", res_c, 0);
    check("midrst res_err", res_err, 0);
    check("midrst busy", busy, 0);
    check("midrst start_ready", start_ready, 0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < TO + 8; c++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("midrst no res_valid", seen, 0);

    resp_delay = 1;
    run_job("job3", pack_m(m3), pack_m(m2), matmul(pack_m(m3), pack_m(m2)), 1'b0, 2, 0);
    resp_delay = TO - 1;
    run_job("collide", pack_m(m2), pack_m(m3), matmul(pack_m(m2), pack_m(m3)), 1'b0, TO, 1);
    never_valid = 1'b1;
    run_job("timeout", pack_m(m1), pack_m(m3), '0, 1'b1, TO, 2);
    never_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
